bch15_dec_sched: RTL and testbench
==================================

BCH15_DEC_SCHED -- requirements
Module: bch15_dec_sched

Interface
REQ-001 Parameter TIMEOUT, default 32: maximum cycles the block waits for decoder ready after the last bit is shifted.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  per-requester codeword valid; index 0 = port A, 1 = port B.
REQ-005 req_cw_a, req_cw_b  input  15 each  codeword, bit 14 = first transmitted (MSB-first).
REQ-006 req_ready  output  2  per-requester accept strobe; a codeword transfers when valid and ready are both high.
REQ-007 dec_enable  output  1  enable to the serial (15,7,5) decoder.
REQ-008 dec_ibit  output  1  serial codeword bit to the decoder.
REQ-009 dec_bsy, dec_rdy, dec_err  input  1 each  decoder busy, ready and uncorrectable status.
REQ-010 dec_outw  input  7  decoder corrected data word.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  consumer accepts result.
REQ-013 res_data  output  7  decoded data word.
REQ-014 res_err  output  1  1 = uncorrectable or timed out.
REQ-015 res_tag  output  1  requester that supplied the codeword (0 = A, 1 = B).
REQ-016 res_tmo  output  1  1 = result produced by timeout, not by the decoder.

Function
REQ-017 FSM states: IDLE, SHIFT, WAIT, CAPTURE, HOLD, RELEASE; IDLE is entered on reset.
REQ-018 IDLE: when any req_valid is high and the result buffer is empty, grant one requester, pulse its req_ready for exactly one cycle, latch its codeword and tag, and go to SHIFT.
REQ-019 Arbitration is round-robin: with both valid, grant the requester not granted last; after reset, A has priority.
REQ-020 SHIFT: dec_enable is high; dec_ibit = latched cw[14 - n] on cycle n (n = 0..14); go to WAIT after n = 14.
REQ-021 WAIT: dec_enable stays high, dec_ibit = 0, and a 6-bit timeout counter increments each cycle.
REQ-022 WAIT: dec_rdy high goes to CAPTURE in the same cycle; the counter reaching TIMEOUT with dec_rdy low also goes to CAPTURE, with res_tmo = 1 and res_err = 1.
REQ-023 If dec_rdy and the timeout occur in the same cycle, dec_rdy wins (res_tmo = 0).
REQ-024 CAPTURE: register dec_outw into res_data and dec_err into res_err (unless timed out), set res_valid, and go to RELEASE.
REQ-025 RELEASE: dec_enable = 0 for exactly 2 cycles, so the decoder returns to idle and clears its syndrome; then go to HOLD.
REQ-026 HOLD: wait until the result buffer is empty (res_valid = 0), then go to IDLE.
REQ-027 res_valid falls on the cycle after res_valid && res_ready. All res_* outputs are stable while res_valid = 1 and res_ready = 0.
REQ-028 A new grant is never issued while res_valid = 1; back-to-back frames are therefore at least 19 + WAIT cycles apart.
REQ-029 dec_bsy is not used for sequencing; it is sampled only by the statistics logic (REQ-034).
REQ-030 req_ready is 0 in every state except the grant cycle in IDLE.
REQ-031 req_valid dropping during SHIFT or WAIT has no effect; the latched codeword is used.

Reset
REQ-032 Asserting rst_n low forces, in the same cycle and at any state including mid-SHIFT: state = IDLE; dec_enable, dec_ibit, req_ready, res_valid, res_err, res_tmo, res_tag = 0; res_data = 7'h00; round-robin pointer = A; timeout counter = 0.
REQ-033 After rst_n is released, the first grant occurs no earlier than the second rising edge.

Configuration
REQ-034 Macro BCH_SCHED_STATS_EN defined: add outputs stat_frames[15:0], stat_uncorr[15:0] and stat_tmo[15:0]; each counter increments once per CAPTURE of the matching kind and saturates at 16'hFFFF. stat_frames counts all frames, stat_uncorr counts res_err = 1, and stat_tmo counts res_tmo = 1. A further output, stat_bsy_err (1 bit), is a sticky flag set when dec_bsy is low during SHIFT n >= 2. All statistics clear on reset.
REQ-035 Macro undefined: these ports and their logic are absent; all other behaviour is identical.

Verification
REQ-036 A sends 15'h0000 -> dec_ibit carries 15 zeros MSB-first; result is res_data = 7'h00, res_err = 0, res_tag = 0.
REQ-037 A sends 15'h01D1, B sends 15'h01D0 (single-bit error) in the same cycle -> A granted first and B second; both results give res_data = 7'h01 and res_err = 0, with tags 0 then 1.
REQ-038 Decoder model holds dec_rdy = 0 -> after TIMEOUT = 32 cycles in WAIT, result is res_err = 1, res_tmo = 1; dec_enable is low for 2 cycles afterwards.
REQ-039 res_ready held low for 10 cycles with both requesters valid -> no req_ready pulse and res_* stable; on res_ready = 1, the next grant follows within 2 cycles.
REQ-040 rst_n pulsed low at SHIFT n = 7 -> all outputs at their reset values immediately; the next frame starts with A and decodes correctly.
REQ-041 With BCH_SCHED_STATS_EN defined, feed 3 good frames, 1 frame with dec_err = 1 and 1 timed-out frame -> stat_frames = 5, stat_uncorr = 2, stat_tmo = 1.

Source files
------------

// File: rtl/bch15_dec_sched.sv
// -----------------------------------------------------------------------------
// bch15_dec_sched
// Scheduler in front of a serial (15,7,5) BCH decoder. It arbitrates between
// two codeword requesters (A and B, round-robin), shifts the accepted codeword
// MSB-first into the decoder, waits for the decoder's ready or a timeout,
// captures the result into a one-entry result buffer and gives the decoder two
// idle cycles so it can clear its syndrome before the next frame.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid[1:0]         codeword valid per requester (0 = A, 1 = B)
//   req_cw_a, req_cw_b     15-bit codewords, bit 14 transmitted first
//   req_ready[1:0]         one-cycle accept strobe per requester
//   dec_enable, dec_ibit   decoder enable and serial bit
//   dec_bsy/rdy/err        decoder busy, ready, uncorrectable status
//   dec_outw[6:0]          decoder corrected data word
//   res_valid/res_ready    result handshake
//   res_data, res_err,     decoded word, error (uncorrectable or timeout),
//   res_tag, res_tmo       requester id, timeout flag
//
// Optional feature: define BCH_SCHED_STATS_EN to add the statistics outputs
//   stat_frames, stat_uncorr, stat_tmo (saturating 16-bit counters) and the
//   sticky stat_bsy_err flag (decoder not busy during shift bit n >= 2).
// -----------------------------------------------------------------------------
module bch15_dec_sched #(
   parameter int TIMEOUT = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   input  logic [14:0] req_cw_a,
   input  logic [14:0] req_cw_b,
   output logic [1:0]  req_ready,
   output logic        dec_enable,
   output logic        dec_ibit,
   input  logic        dec_bsy,
   input  logic        dec_rdy,
   input  logic        dec_err,
   input  logic [6:0]  dec_outw,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [6:0]  res_data,
   output logic        res_err,
   output logic        res_tag,
   output logic        res_tmo
`ifdef BCH_SCHED_STATS_EN
   ,
   output logic [15:0] stat_frames,
   output logic [15:0] stat_uncorr,
   output logic [15:0] stat_tmo,
   output logic        stat_bsy_err
`endif
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SHIFT   = 3'd1,
      WAIT    = 3'd2,
      CAPTURE = 3'd3,
      HOLD    = 3'd4,
      RELEASE = 3'd5
   } state_t;

   // Counter value seen in the last WAIT cycle before the timeout fires.
   localparam logic [5:0] TMO_LAST = 6'(TIMEOUT - 1);

   state_t      state_r;
   state_t      state_s;
   logic [1:0]  req_ready_r;
   logic [13:0] sh_r;          // remaining codeword bits; bit 14 goes out on the grant edge
   logic        tag_r;
   logic        prio_r;        // requester favoured when both are valid
   logic        armed_r;       // low for the first cycle after reset
   logic [3:0]  bit_cnt_r;
   logic [5:0]  tmo_cnt_r;
   logic        rel_cnt_r;
   logic        dec_enable_r;
   logic        dec_ibit_r;
   logic [6:0]  cap_data_r;
   logic        cap_err_r;
   logic        cap_tmo_r;
   logic        res_valid_r;
   logic [6:0]  res_data_r;
   logic        res_err_r;
   logic        res_tag_r;
   logic        res_tmo_r;

   logic        arm_s;
   logic        xfer_s;
   logic        gnt_tag_s;
   logic [1:0]  gnt_oh_s;
   logic [14:0] cw_sel_s;

   // Round-robin pick and codeword mux for the requester holding the grant.
   always_comb begin
      gnt_tag_s = 1'b0;
      if (req_valid == 2'b11) begin
         gnt_tag_s = prio_r;
      end else if (req_valid[1]) begin
         gnt_tag_s = 1'b1;
      end else begin
         gnt_tag_s = 1'b0;
      end
      gnt_oh_s = gnt_tag_s ? 2'b10 : 2'b01;
      cw_sel_s = req_ready_r[1] ? req_cw_b : req_cw_a;
   end

   // Next-state logic. The grant is armed in one IDLE cycle and the
   // req_ready pulse of the following cycle is the transfer cycle.
   always_comb begin
      state_s = state_r;
      arm_s   = 1'b0;
      xfer_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_ready_r != 2'b00) begin
               if ((req_valid & req_ready_r) != 2'b00) begin
                  xfer_s  = 1'b1;
                  state_s = SHIFT;
               end else begin
                  state_s = IDLE;
               end
            end else if (armed_r && (req_valid != 2'b00) && !res_valid_r) begin
               arm_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            if (bit_cnt_r == 4'd14) begin
               state_s = WAIT;
            end else begin
               state_s = SHIFT;
            end
         end
         WAIT: begin
            if (dec_rdy || (tmo_cnt_r == TMO_LAST)) begin
               state_s = CAPTURE;
            end else begin
               state_s = WAIT;
            end
         end
         CAPTURE: state_s = RELEASE;
         RELEASE: begin
            if (rel_cnt_r) begin
               state_s = HOLD;
            end else begin
               state_s = RELEASE;
            end
         end
         HOLD: begin
            // Leave as soon as the buffer is empty on the next cycle.
            if (!res_valid_r || res_ready) begin
               state_s = IDLE;
            end else begin
               state_s = HOLD;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Grant strobe, codeword/tag latch and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_r     <= 1'b0;
         req_ready_r <= 2'b00;
         sh_r        <= 14'h0000;
         tag_r       <= 1'b0;
         prio_r      <= 1'b0;
      end else begin
         armed_r     <= 1'b1;
         req_ready_r <= arm_s ? gnt_oh_s : 2'b00;
         if (xfer_s) begin
            sh_r   <= cw_sel_s[13:0];
            tag_r  <= req_ready_r[1];
            prio_r <= ~req_ready_r[1];
         end else if (state_r == SHIFT) begin
            sh_r <= {sh_r[12:0], 1'b0};
         end
      end
   end

   // Cycle counters for shift, wait timeout and release phases.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_r <= 4'd0;
         tmo_cnt_r <= 6'd0;
         rel_cnt_r <= 1'b0;
      end else begin
         bit_cnt_r <= (state_r == SHIFT)   ? bit_cnt_r + 4'd1 : 4'd0;
         tmo_cnt_r <= (state_r == WAIT)    ? tmo_cnt_r + 6'd1 : 6'd0;
         rel_cnt_r <= (state_r == RELEASE) ? ~rel_cnt_r : 1'b0;
      end
   end

   // Decoder drive, registered so it lines up with the state it belongs to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_enable_r <= 1'b0;
         dec_ibit_r   <= 1'b0;
      end else begin
         dec_enable_r <= (state_s == SHIFT) || (state_s == WAIT) || (state_s == CAPTURE);
         if (xfer_s) begin
            dec_ibit_r <= cw_sel_s[14];
         end else if ((state_r == SHIFT) && (state_s == SHIFT)) begin
            dec_ibit_r <= sh_r[13];
         end else begin
            dec_ibit_r <= 1'b0;
         end
      end
   end

   // Decoder result staging; a ready in the timeout cycle takes precedence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_data_r <= 7'h00;
         cap_err_r  <= 1'b0;
         cap_tmo_r  <= 1'b0;
      end else if ((state_r == WAIT) && (state_s == CAPTURE)) begin
         cap_data_r <= dec_rdy ? dec_outw : 7'h00;
         cap_err_r  <= dec_rdy ? dec_err : 1'b1;
         cap_tmo_r  <= ~dec_rdy;
      end
   end

   // One-entry result buffer; fields only change when a new result loads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid_r <= 1'b0;
         res_data_r  <= 7'h00;
         res_err_r   <= 1'b0;
         res_tag_r   <= 1'b0;
         res_tmo_r   <= 1'b0;
      end else if (state_r == CAPTURE) begin
         res_valid_r <= 1'b1;
         res_data_r  <= cap_data_r;
         res_err_r   <= cap_err_r;
         res_tag_r   <= tag_r;
         res_tmo_r   <= cap_tmo_r;
      end else if (res_valid_r && res_ready) begin
         res_valid_r <= 1'b0;
      end
   end

   assign req_ready  = req_ready_r;
   assign dec_enable = dec_enable_r;
   assign dec_ibit   = dec_ibit_r;
   assign res_valid  = res_valid_r;
   assign res_data   = res_data_r;
   assign res_err    = res_err_r;
   assign res_tag    = res_tag_r;
   assign res_tmo    = res_tmo_r;

`ifdef BCH_SCHED_STATS_EN
   logic [15:0] st_frames_r;
   logic [15:0] st_uncorr_r;
   logic [15:0] st_tmo_r;
   logic        st_bsy_err_r;

   // Saturating per-frame statistics and sticky decoder-busy check.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_frames_r  <= 16'h0000;
         st_uncorr_r  <= 16'h0000;
         st_tmo_r     <= 16'h0000;
         st_bsy_err_r <= 1'b0;
      end else begin
         if (state_r == CAPTURE) begin
            if (st_frames_r != 16'hFFFF) begin
               st_frames_r <= st_frames_r + 16'h0001;
            end
            if (cap_err_r && (st_uncorr_r != 16'hFFFF)) begin
               st_uncorr_r <= st_uncorr_r + 16'h0001;
            end
            if (cap_tmo_r && (st_tmo_r != 16'hFFFF)) begin
               st_tmo_r <= st_tmo_r + 16'h0001;
            end
         end
         if ((state_r == SHIFT) && (bit_cnt_r >= 4'd2) && !dec_bsy) begin
            st_bsy_err_r <= 1'b1;
         end
      end
   end

   assign stat_frames  = st_frames_r;
   assign stat_uncorr  = st_uncorr_r;
   assign stat_tmo     = st_tmo_r;
   assign stat_bsy_err = st_bsy_err_r;
`else
   // Busy status only feeds the statistics logic.
   logic bsy_unused_s;
   assign bsy_unused_s = dec_bsy;
`endif

endmodule

// File: tb/tb_bch15_dec_sched.sv
// -----------------------------------------------------------------------------
// tb_bch15_dec_sched
// Directed bench for bch15_dec_sched. A behavioural stub stands in for the
// serial decoder: it collects the 15 shifted bits, and after a programmable
// latency reports the top 7 received bits as data (all vectors used here have
// error-free data bits) with a programmable uncorrectable flag.
// Define BCH_SCHED_STATS_EN to also connect and check the statistics outputs.
// -----------------------------------------------------------------------------
module tb_bch15_dec_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [14:0] req_cw_a;
   logic [14:0] req_cw_b;
   logic [1:0]  req_ready;
   logic        dec_enable;
   logic        dec_ibit;
   logic        dec_bsy = 1'b0;
   logic        dec_rdy = 1'b0;
   logic        dec_err = 1'b0;
   logic [6:0]  dec_outw = 7'h00;
   logic        res_valid;
   logic        res_ready;
   logic [6:0]  res_data;
   logic        res_err;
   logic        res_tag;
   logic        res_tmo;
`ifdef BCH_SCHED_STATS_EN
   logic [15:0] stat_frames;
   logic [15:0] stat_uncorr;
   logic [15:0] stat_tmo;
   logic        stat_bsy_err;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;

   // decoder stub state
   int          m_cnt = 0;
   int          m_lat = 0;
   int          lat = 2;
   logic        hold_rdy = 1'b0;
   logic        force_err = 1'b0;
   logic [14:0] m_sh = 15'h0000;
   logic [14:0] got_cw = 15'h0000;

   always #5 clk = ~clk;

   bch15_dec_sched #(.TIMEOUT(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_cw_a   (req_cw_a),
      .req_cw_b   (req_cw_b),
      .req_ready  (req_ready),
      .dec_enable (dec_enable),
      .dec_ibit   (dec_ibit),
      .dec_bsy    (dec_bsy),
      .dec_rdy    (dec_rdy),
      .dec_err    (dec_err),
      .dec_outw   (dec_outw),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_err    (res_err),
      .res_tag    (res_tag),
      .res_tmo    (res_tmo)
`ifdef BCH_SCHED_STATS_EN
      ,
      .stat_frames  (stat_frames),
      .stat_uncorr  (stat_uncorr),
      .stat_tmo     (stat_tmo),
      .stat_bsy_err (stat_bsy_err)
`endif
   );

   // Decoder stub, evaluated mid-cycle so its outputs are settled at posedge.
   always @(negedge clk) begin
      if (!rst_n || !dec_enable) begin
         m_cnt   = 0;
         m_lat   = 0;
         dec_rdy = 1'b0;
         dec_bsy = 1'b0;
      end else if (m_cnt < 15) begin
         m_sh    = {m_sh[13:0], dec_ibit};
         m_cnt   = m_cnt + 1;
         dec_bsy = 1'b1;
         if (m_cnt == 15) got_cw = m_sh;
      end else if (!hold_rdy && (m_lat >= lat)) begin
         dec_rdy  = 1'b1;
         dec_outw = m_sh[14:8];
         dec_err  = force_err;
         dec_bsy  = 1'b0;
      end else begin
         m_lat = m_lat + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (obs !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a req_ready pulse and check which requester got it.
   task automatic grant(input logic [1:0] exp);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready != 2'b00) break;
      end
      check("grant", 32'(req_ready), 32'(exp));
   endtask

   // Called at the grant cycle: follows the frame to its result and checks it.
   task automatic run_frame(input logic [1:0] drop, input int exp_cyc, input logic chk_data,
                            input logic [6:0] e_data, input logic e_err, input logic e_tmo,
                            input logic e_tag, input logic [14:0] e_cw);
      int cyc;
      int en;
      cyc = 0;
      en  = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         cyc = cyc + 1;
         if (cyc == 1) begin
            check("gnt_pulse", 32'(req_ready), 32'd0);
            req_valid = req_valid & ~drop;
         end
         if (dec_enable) en = en + 1;
         if (res_valid) break;
      end
      check("res_valid", 32'(res_valid), 32'd1);
      check("latency", 32'(cyc), 32'(exp_cyc));
      check("enable_cycles", 32'(en), 32'(exp_cyc - 1));
      check("cw_bits", 32'(got_cw), 32'(e_cw));
      if (chk_data) check("res_data", 32'(res_data), 32'(e_data));
      check("res_err", 32'(res_err), 32'(e_err));
      check("res_tmo", 32'(res_tmo), 32'(e_tmo));
      check("res_tag", 32'(res_tag), 32'(e_tag));
   endtask

   task automatic consume();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("res_drop", 32'(res_valid), 32'd0);
   endtask

   task automatic check_reset_outs(input string tag);
      check(tag, 32'({req_ready, dec_enable, dec_ibit, res_valid, res_err,
                      res_tmo, res_tag, res_data}), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      res_ready = 1'b0;
      req_valid = 2'b11;
      req_cw_a  = 15'h01D1;
      req_cw_b  = 15'h01D0;

      // Reset state, then first grant only after the second rising edge.
      repeat (2) @(negedge clk);
      check_reset_outs("reset_outs");
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_1", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("post_rst_2", 32'(req_ready), 32'd1);

      // Simultaneous A and B: A first, then B (single-bit parity error).
      run_frame(2'b01, 20, 1'b1, 7'h01, 1'b0, 1'b0, 1'b0, 15'h01D1);
      consume();
      grant(2'b10);
      run_frame(2'b10, 20, 1'b1, 7'h01, 1'b0, 1'b0, 1'b1, 15'h01D0);

      // Result held for 10 cycles with both requesters valid.
      req_valid = 2'b11;
      req_cw_a  = 15'h0000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_stable", 32'({res_valid, res_data, res_err, res_tmo, res_tag, req_ready}),
               32'({1'b1, 7'h01, 1'b0, 1'b0, 1'b1, 2'b00}));
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("free_valid", 32'(res_valid), 32'd0);
      @(negedge clk);
      check("gnt_after_free", 32'(req_ready), 32'd1);
      // All-zero codeword from A.
      run_frame(2'b11, 20, 1'b1, 7'h00, 1'b0, 1'b0, 1'b0, 15'h0000);
      consume();

      // Uncorrectable report from the decoder (B).
      force_err = 1'b1;
      req_cw_b  = 15'h01D1;
      req_valid = 2'b10;
      grant(2'b10);
      run_frame(2'b10, 20, 1'b1, 7'h01, 1'b1, 1'b0, 1'b1, 15'h01D1);
      consume();
      force_err = 1'b0;

      // Decoder never ready: 15 shift + 32 wait + capture, then release.
      hold_rdy  = 1'b1;
      req_cw_a  = 15'h01D1;
      req_valid = 2'b01;
      grant(2'b01);
      run_frame(2'b01, 49, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 15'h01D1);
      check("release_en_0", 32'(dec_enable), 32'd0);
      @(negedge clk);
      check("release_en_1", 32'(dec_enable), 32'd0);
      consume();
      hold_rdy = 1'b0;

`ifdef BCH_SCHED_STATS_EN
      check("stat_frames", 32'(stat_frames), 32'd5);
      check("stat_uncorr", 32'(stat_uncorr), 32'd2);
      check("stat_tmo", 32'(stat_tmo), 32'd1);
      check("stat_bsy_err", 32'(stat_bsy_err), 32'd0);
`endif

      // Reset in the middle of B's shift (bit n = 7), then A wins again.
      req_cw_b  = 15'h01D0;
      req_valid = 2'b11;
      grant(2'b10);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 1) check("gnt_pulse_b", 32'(req_ready), 32'd0);
      end
      check("mid_shift_en", 32'(dec_enable), 32'd1);
      check("mid_shift_bit7", 32'(dec_ibit), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outs("mid_reset_outs");
`ifdef BCH_SCHED_STATS_EN
      check("stat_clear", 32'({stat_frames, stat_tmo}), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rerst_1", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("rerst_2", 32'(req_ready), 32'd1);
      run_frame(2'b11, 20, 1'b1, 7'h01, 1'b0, 1'b0, 1'b0, 15'h01D1);
      consume();

      // Ready arrives in the very cycle the timeout expires: ready wins.
      lat       = 31;
      req_valid = 2'b10;
      grant(2'b10);
      run_frame(2'b10, 49, 1'b1, 7'h01, 1'b0, 1'b0, 1'b1, 15'h01D0);
      consume();
      lat = 2;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
      $fatal(1);
   end

endmodule
